// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requester and serial_adder_ctrl.
// The sub input exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif

  modport master (
    output start, output a, output b,
    input  busy,  input  done, input sum, input cout
`ifdef SERIAL_ADDER_SUB_EN
    , output sub
`endif
  );

  modport slave (
    input  start, input  a,    input  b,
    output busy,  output done, output sum, output cout
`ifdef SERIAL_ADDER_SUB_EN
    , input sub
`endif
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder slice (two half adders) reused LSB first.
// Define SERIAL_ADDER_SUB_EN to add a sub input that computes A-B instead of A+B.
module half_adder (
  input  logic x_i,
  input  logic y_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i;
  assign c_o = x_i & y_i;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_adder_ctrl_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             ha0_s, ha0_c, ha1_c, slice_s, slice_c;
  logic             cin;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert B on load and inject a carry of 1.
  assign cin = bus.sub;
`else
  assign cin = 1'b0;
`endif

  half_adder u_ha0 (.x_i(a_q[0]), .y_i(b_q[0]),  .s_o(ha0_s),   .c_o(ha0_c));
  half_adder u_ha1 (.x_i(ha0_s),  .y_i(carry_q), .s_o(slice_s), .c_o(ha1_c));
  assign slice_c = ha0_c | ha1_c;

  // NOTE: every signal gets its hold value before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          a_d     = bus.a;
          b_d     = cin ? ~bus.b : bus.b;
          carry_d = cin;
          cnt_d   = '0;
          res_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_d   = {slice_s, res_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = slice_c;
        cnt_d   = cnt_q + 1'b1;
        // Results become visible only here, so partial sums never reach the outputs.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          sum_d   = {slice_s, res_q[WIDTH-1:1]};
          cout_d  = slice_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8); inputs driven and outputs sampled on the falling edge.
module tb_serial_adder_ctrl;
  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  serial_adder_ctrl_if #(.WIDTH(8)) bus ();

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands with start for exactly one rising edge; returns at the falling edge after it.
  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input logic [7:0] held, output int busy_n, output bit timed_out,
                           output bit overlap, output bit moved, output int done_cyc);
    busy_n    = 0;
    timed_out = 1'b1;
    overlap   = 1'b0;
    moved     = 1'b0;
    done_cyc  = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy && bus.done) overlap = 1'b1;
      if (bus.done) begin
        timed_out = 1'b0;
        done_cyc  = cyc;
        break;
      end
      if (bus.busy) busy_n++;
      if (bus.sum !== held) moved = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] held, input int exp_busy,
                              input logic [7:0] es, input logic ec, output int done_cyc);
    int busy_n;
    bit to, ov, mv;
    wait_done(held, busy_n, to, ov, mv, done_cyc);
    check({tag, "_timeout"}, to, 0);
    check({tag, "_busy_cycles"}, busy_n, exp_busy);
    check({tag, "_busy_done_overlap"}, ov, 0);
    check({tag, "_partial_visible"}, mv, 0);
    check({tag, "_sum"}, bus.sum, es);
    check({tag, "_cout"}, bus.cout, ec);
  endtask

  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] es, input logic ec);
    logic [7:0] held;
    int dc;
    held = bus.sum;
    launch(a, b);
    check_result(tag, held, 8, es, ec, dc);
    @(negedge clk);
    check({tag, "_done_fall"}, bus.done, 0);
    check({tag, "_idle_busy"}, bus.busy, 0);
    check({tag, "_sum_hold"}, bus.sum, es);
  endtask

  initial begin
    int dc1, dc2, n_done;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_sum", bus.sum, 8'h00);
    check("rst_cout", bus.cout, 0);
    rst = 1'b0;
    @(negedge clk);

    do_op("add_0f_01", 8'h0F, 8'h01, 8'h10, 1'b0);
    do_op("ovf_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
    do_op("ovf_ff_ff", 8'hFF, 8'hFF, 8'hFE, 1'b1);

    // start pulse at E3 while running must be ignored
    launch(8'h12, 8'h34);
    repeat (2) @(negedge clk);
    bus.a     = 8'hAA;
    bus.b     = 8'hAA;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_result("busy_ign", 8'hFE, 5, 8'h46, 1'b0, dc1);
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("busy_ign_extra_done", n_done, 0);
    check("busy_ign_idle", bus.busy, 0);

    // reset sampled at E4 of 0x80+0x80
    launch(8'h80, 8'h80);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_sum", bus.sum, 8'h00);
    check("midrst_cout", bus.cout, 0);
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("midrst_no_done", n_done, 0);
    do_op("after_rst", 8'h01, 8'h02, 8'h03, 1'b0);

    // start held high: accepted again in the DONE cycle
    bus.a     = 8'h01;
    bus.b     = 8'h01;
    bus.start = 1'b1;
    @(negedge clk);
    bus.a     = 8'h7F;
    bus.b     = 8'h01;
    check_result("b2b_1", 8'h03, 8, 8'h02, 1'b0, dc1);
    @(negedge clk);
    check("b2b_rebusy", bus.busy, 1);
    check("b2b_done_low", bus.done, 0);
    check_result("b2b_2", 8'h02, 8, 8'h80, 1'b0, dc2);
    check("b2b_period", dc2 - dc1, 9);
    bus.start = 1'b0;
    @(negedge clk);
    check("b2b_end_busy", bus.busy, 0);
    check("b2b_end_done", bus.done, 0);

`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = 1'b1;
    do_op("sub_05_07", 8'h05, 8'h07, 8'hFE, 1'b0);
    do_op("sub_07_05", 8'h07, 8'h05, 8'h02, 1'b1);
    bus.sub = 1'b0;
    do_op("sub0_add", 8'h07, 8'h05, 8'h0C, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
